// File: rtl/tug_pkg.sv
// Shared types and width constants for the tug-of-war referee.
//   state_t : round/match phase (PLAY, HOLD, DONE)
//   POS_W / SCORE_W : width helpers derived from the default parameter set;
//   modules that receive overridden parameters re-derive them locally.
package tug_pkg;

  typedef enum logic [1:0] {
    PLAY,
    HOLD,
    DONE
  } state_t;

  localparam int unsigned DEF_NUM_LIGHTS  = 9;
  localparam int unsigned DEF_WIN_SCORE   = 7;
  localparam int unsigned DEF_HOLD_CYCLES = 50_000_000;

  localparam int unsigned POS_W   = $clog2(DEF_NUM_LIGHTS);
  localparam int unsigned SCORE_W = $clog2(DEF_WIN_SCORE + 1);

endpackage

// File: rtl/tug_hold_timer.sv
// Post-round freeze timer.
//   clk, reset : system clock, synchronous active-high reset
//   start      : clears the counter (asserted on the round-win edge)
//   run        : counts while high (asserted throughout HOLD)
//   done       : one-cycle pulse during the HOLD_CYCLES-th running cycle
module tug_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic run,
  output logic done
);

  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  // Counter holds (running cycles - 1), so done lines up with the last HOLD cycle.
  assign done = run && (r_cnt == CW'(HOLD_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || start || done) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tug_referee.sv
// Tug-of-war referee: moves the playfield light on press pulses, detects
// round wins, keeps both scores and declares the match winner.
//   clk, reset      : system clock, synchronous active-high reset
//   press_l/press_r : single-cycle press pulses (human / cyber)
//   cyber_enable    : high only while a round is live (PLAY)
//   leds            : one-hot light position
//   score_l/score_r : round wins per side
//   round_win_l/r   : one-cycle pulse on a round win
//   match_over      : high once the match is decided (DONE)
//   winner_l        : 1 = human took the match, valid while match_over
module tug_referee
  import tug_pkg::*;
#(
  parameter int unsigned NUM_LIGHTS  = 9,
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               press_l,
  input  logic                               press_r,
  output logic                               cyber_enable,
  output logic [NUM_LIGHTS-1:0]              leds,
  output logic [$clog2(WIN_SCORE+1)-1:0]     score_l,
  output logic [$clog2(WIN_SCORE+1)-1:0]     score_r,
  output logic                               round_win_l,
  output logic                               round_win_r,
  output logic                               match_over,
  output logic                               winner_l
);

  localparam int unsigned PW = $clog2(NUM_LIGHTS);
  localparam int unsigned SW = $clog2(WIN_SCORE + 1);
  localparam logic [PW-1:0] CENTER = PW'(NUM_LIGHTS / 2);
  localparam logic [PW-1:0] LAST   = PW'(NUM_LIGHTS - 1);
  localparam logic [SW-1:0] TARGET = SW'(WIN_SCORE);

  state_t        r_state;
  logic [PW-1:0] r_pos;
  logic [SW-1:0] r_score_l;
  logic [SW-1:0] r_score_r;
  logic          r_round_win_l;
  logic          r_round_win_r;
  logic          r_winner_l;

  logic          w_push_l;
  logic          w_push_r;
  logic          w_win_l;
  logic          w_win_r;
  logic          w_hold_done;
  logic [SW-1:0] w_score_l_inc;
  logic [SW-1:0] w_score_r_inc;

  // Simultaneous presses cancel out.
  assign w_push_l      = (r_state == PLAY) && press_l && !press_r;
  assign w_push_r      = (r_state == PLAY) && press_r && !press_l;
  assign w_win_l       = w_push_l && (r_pos == LAST);
  assign w_win_r       = w_push_r && (r_pos == '0);
  assign w_score_l_inc = r_score_l + SW'(1);
  assign w_score_r_inc = r_score_r + SW'(1);

  tug_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk  (clk),
    .reset(reset),
    .start(w_win_l || w_win_r),
    .run  (r_state == HOLD),
    .done (w_hold_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= PLAY;
      r_pos         <= CENTER;
      r_score_l     <= '0;
      r_score_r     <= '0;
      r_round_win_l <= 1'b0;
      r_round_win_r <= 1'b0;
      r_winner_l    <= 1'b0;
    end else begin
      r_round_win_l <= 1'b0;
      r_round_win_r <= 1'b0;
      case (r_state)
        PLAY: begin
          if (w_win_l) begin
            r_score_l     <= w_score_l_inc;
            r_round_win_l <= 1'b1;
            if (w_score_l_inc == TARGET) begin
              r_state    <= DONE;
              r_winner_l <= 1'b1;
            end else begin
              r_state <= HOLD;
            end
          end else if (w_win_r) begin
            r_score_r     <= w_score_r_inc;
            r_round_win_r <= 1'b1;
            if (w_score_r_inc == TARGET) begin
              r_state    <= DONE;
              r_winner_l <= 1'b0;
            end else begin
              r_state <= HOLD;
            end
          end else if (w_push_l) begin
            r_pos <= r_pos + PW'(1);
          end else if (w_push_r) begin
            r_pos <= r_pos - PW'(1);
          end
        end
        HOLD: begin
          if (w_hold_done) begin
            r_pos   <= CENTER;
            r_state <= PLAY;
          end
        end
        DONE: begin
        end
        default: r_state <= PLAY;
      endcase
    end
  end

  always_comb begin
    leds = '0;
    for (int unsigned i = 0; i < NUM_LIGHTS; i++) begin
      leds[i] = (r_pos == PW'(i));
    end
  end

  assign cyber_enable = (r_state == PLAY);
  assign match_over   = (r_state == DONE);
  assign score_l      = r_score_l;
  assign score_r      = r_score_r;
  assign round_win_l  = r_round_win_l;
  assign round_win_r  = r_round_win_r;
  assign winner_l     = r_winner_l;

endmodule

// File: tb/tb_tug_referee.sv
// Self-checking bench for tug_referee (9 lights, 3 to win, 4-cycle hold).
module tb_tug_referee;

  localparam int N = 9;
  localparam int W = 3;
  localparam int H = 4;
  localparam int C = N / 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         press_l;
  logic         press_r;
  logic         cyber_enable;
  logic [N-1:0] leds;
  logic [1:0]   score_l;
  logic [1:0]   score_r;
  logic         round_win_l;
  logic         round_win_r;
  logic         match_over;
  logic         winner_l;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: light index, scores, remaining freeze cycles, match flags.
  int m_pos  = C;
  int m_sl   = 0;
  int m_sr   = 0;
  int m_hold = 0;
  bit m_over = 0;
  bit m_win  = 0;
  bit m_rwl  = 0;
  bit m_rwr  = 0;

  always #5 clk = ~clk;

  tug_referee #(
    .NUM_LIGHTS (N),
    .WIN_SCORE  (W),
    .HOLD_CYCLES(H)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .press_l     (press_l),
    .press_r     (press_r),
    .cyber_enable(cyber_enable),
    .leds        (leds),
    .score_l     (score_l),
    .score_r     (score_r),
    .round_win_l (round_win_l),
    .round_win_r (round_win_r),
    .match_over  (match_over),
    .winner_l    (winner_l)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_step(input bit l, input bit r, input bit rst);
    m_rwl = 0;
    m_rwr = 0;
    if (rst) begin
      m_pos = C; m_sl = 0; m_sr = 0; m_hold = 0; m_over = 0; m_win = 0;
    end else if (m_over) begin
      // match decided: everything frozen
    end else if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) m_pos = C;
    end else if (l && !r) begin
      if (m_pos == N - 1) begin
        m_sl++; m_rwl = 1;
        if (m_sl == W) begin m_over = 1; m_win = 1; end
        else m_hold = H;
      end else m_pos++;
    end else if (r && !l) begin
      if (m_pos == 0) begin
        m_sr++; m_rwr = 1;
        if (m_sr == W) begin m_over = 1; m_win = 0; end
        else m_hold = H;
      end else m_pos--;
    end
  endtask

  task automatic check_all();
    logic [N-1:0] e_leds;
    e_leds = '0;
    e_leds[m_pos] = 1'b1;
    chk("leds",         32'(leds),         32'(e_leds));
    chk("score_l",      32'(score_l),      32'(m_sl));
    chk("score_r",      32'(score_r),      32'(m_sr));
    chk("round_win_l",  32'(round_win_l),  32'(m_rwl));
    chk("round_win_r",  32'(round_win_r),  32'(m_rwr));
    chk("cyber_enable", 32'(cyber_enable), 32'(!m_over && m_hold == 0));
    chk("match_over",   32'(match_over),   32'(m_over));
    chk("winner_l",     32'(winner_l),     32'(m_win));
  endtask

  // One clock: drive at negedge, model the edge, sample 1 time unit later.
  task automatic cyc(input bit l, input bit r, input bit rst);
    press_l = l;
    press_r = r;
    reset   = rst;
    @(posedge clk);
    model_step(l, r, rst);
    #1;
    check_all();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; press_l = 1'b0; press_r = 1'b0;
    @(negedge clk);

    // 1. reset state
    cyc(0, 0, 1);
    cyc(1, 1, 1);
    chk("rst_leds", 32'(leds), 32'(9'b000010000));
    chk("rst_cyber", 32'(cyber_enable), 32'd1);

    // 2. left round win from center, idle hold
    repeat (4) cyc(1, 0, 0);
    chk("at_edge_l", 32'(leds), 32'(9'b100000000));
    cyc(1, 0, 0);
    chk("rw_l_pulse", 32'(round_win_l), 32'd1);
    chk("score_l_1", 32'(score_l), 32'd1);
    chk("hold_pos_edge", 32'(leds), 32'(9'b100000000));
    repeat (3) cyc(0, 0, 0);
    chk("hold_cyber_off", 32'(cyber_enable), 32'd0);
    cyc(0, 0, 0);
    chk("resume_center", 32'(leds), 32'(9'b000010000));
    chk("resume_cyber", 32'(cyber_enable), 32'd1);

    // 3. simultaneous presses cancel; single right press moves one step
    cyc(1, 1, 0);
    chk("both_cancel", 32'(leds), 32'(9'b000010000));
    cyc(0, 1, 0);
    chk("right_step", 32'(leds), 32'(9'b000001000));
    cyc(1, 0, 0);

    // 4. second left win, presses during hold (incl. last cycle) are dropped
    repeat (5) cyc(1, 0, 0);
    chk("score_l_2", 32'(score_l), 32'd2);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    cyc(1, 1, 0);
    cyc(0, 1, 0);
    chk("hold_drop_center", 32'(leds), 32'(9'b000010000));
    chk("hold_drop_score", 32'(score_l), 32'd2);

    // 6. reset in the second hold cycle
    repeat (5) cyc(0, 1, 0);
    chk("rw_r_pulse", 32'(round_win_r), 32'd1);
    cyc(0, 0, 0);
    cyc(1, 0, 1);
    chk("midhold_rst_score_l", 32'(score_l), 32'd0);
    chk("midhold_rst_cyber", 32'(cyber_enable), 32'd1);
    chk("midhold_rst_leds", 32'(leds), 32'(9'b000010000));

    // 5. right side takes the match, then everything frozen
    repeat (W) begin
      repeat (5) cyc(0, 1, 0);
      repeat (H) cyc(0, 0, 0);
    end
    chk("done_match_over", 32'(match_over), 32'd1);
    chk("done_winner_l", 32'(winner_l), 32'd0);
    chk("done_score_r", 32'(score_r), 32'd3);
    repeat (20) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    chk("frozen_leds", 32'(leds), 32'(9'b000000001));

    // Randomized play, alternating bias so both sides win matches.
    for (int blk = 0; blk < 6; blk++) begin
      int pl;
      int pr;
      pl = (blk % 2 == 0) ? 70 : 25;
      pr = (blk % 2 == 0) ? 25 : 70;
      cyc(0, 0, 1);
      for (int k = 0; k < 400; k++) begin
        cyc(bit'($urandom_range(0, 99) < pl), bit'($urandom_range(0, 99) < pr),
            bit'($urandom_range(0, 299) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
